// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: hazard controller states and register-number width.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } ctrl_state_t;

  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: flags an ID-stage read of the register an EX-stage load writes.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_uses_rt,
  output logic     load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_dREN && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait FSM, served-access mask,
// stall/flush steering and a saturating stall-cycle counter.
module hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        halt_mem,
  input  logic        ex_dREN,
  input  regbits_t    ex_wsel,
  input  regbits_t    id_rs,
  input  regbits_t    id_rt,
  input  logic        id_uses_rt,
  input  logic        branch_taken,
  input  logic        jump_id,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        back_en,
  output logic        dmem_mask,
  output logic        halted,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles
);

  ctrl_state_t state, next_state;
  logic        load_use;
  logic        mem_access;
  logic        dmem_done;
  logic        advance;

  hazard_detect u_detect (
    .ex_dREN    (ex_dREN),
    .ex_wsel    (ex_wsel),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // A masked access was already served while IF was still waiting.
  assign mem_access = mem_dREN | mem_dWEN;
  assign dmem_done  = !mem_access | dhit | dmem_mask;
  assign advance    = (state != HALT) & ihit & dmem_done;
  assign ctrl_state = state;

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (halt_mem && advance)
          next_state = HALT;
        else if (mem_access && !dhit && !dmem_mask)
          next_state = DWAIT;
      end
      DWAIT: begin
        if (halt_mem && advance)
          next_state = HALT;
        else if (dhit)
          next_state = RUN;
      end
      default: next_state = HALT;
    endcase
  end

  // Branch redirect outranks load-use, which in turn suppresses a jump flush.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    back_en    = 1'b0;
    if (advance) begin
      idex_en = 1'b1;
      back_en = 1'b1;
      if (branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = jump_id;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= RUN;
      dmem_mask    <= 1'b0;
      halted       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state  <= next_state;
      halted <= (next_state == HALT);
      if (state == HALT)
        dmem_mask <= 1'b0;
      else if (dhit && !ihit)
        dmem_mask <= 1'b1;
      else if (advance)
        dmem_mask <= 1'b0;
      if ((state != HALT) && !pc_en && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: hand-derived expectations queued per cycle and checked before the edge.
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        ihit, dhit, mem_dREN, mem_dWEN, halt_mem, ex_dREN;
  regbits_t    ex_wsel, id_rs, id_rt;
  logic        id_uses_rt, branch_taken, jump_id;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, back_en;
  logic        dmem_mask, halted;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;

  logic [41:0] obs;
  logic [41:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, back_en}
  localparam logic [5:0] EN_OFF = 6'b000000;
  localparam logic [5:0] EN_ALL = 6'b110101;
  localparam logic [5:0] EN_LU  = 6'b000111;
  localparam logic [5:0] EN_BR  = 6'b111111;
  localparam logic [5:0] EN_JMP = 6'b111101;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .halt_mem(halt_mem),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .jump_id(jump_id),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .back_en(back_en),
    .dmem_mask(dmem_mask), .halted(halted), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles)
  );

  assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, back_en,
                dmem_mask, halted, ctrl_state, stall_cycles};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [24:0] si(input logic rst, input logic ih, input logic dh,
                                     input logic mr, input logic mw, input logic hm,
                                     input logic exr, input logic [4:0] ws,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic urt, input logic bt, input logic j);
    return {rst, ih, dh, mr, mw, hm, exr, ws, rs, rt, urt, bt, j};
  endfunction

  function automatic logic [41:0] ex(input logic [5:0] en, input logic m, input logic h,
                                     input logic [1:0] st, input logic [31:0] stall);
    return {en, m, h, st, stall};
  endfunction

  task automatic apply_stimulus(input logic [24:0] s);
    {RST, ihit, dhit, mem_dREN, mem_dWEN, halt_mem, ex_dREN, ex_wsel, id_rs, id_rt,
     id_uses_rt, branch_taken, jump_id} = s;
  endtask

  task automatic test_reset();
    logic [24:0] st[3];
    logic [41:0] ev[3];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,0,0,0,0,0,0,0,0,0,0,0,0),
           si(0,1,0,0,0,0,0,0,0,0,0,0,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_OFF,0,0,0,0), ex(EN_ALL,0,0,0,1)};
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL reset step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_normal();
    logic [24:0] st[5];
    logic [41:0] ev[5];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,1,0,0,0,0,0,8,8,0,0,0,0),
           si(0,1,0,0,0,0,1,0,0,0,1,0,0), si(0,1,0,0,0,0,1,8,3,8,0,0,0),
           si(0,1,1,1,0,0,0,0,0,0,0,0,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_ALL,0,0,0,0), ex(EN_ALL,0,0,0,0),
           ex(EN_ALL,0,0,0,0), ex(EN_ALL,0,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL normal step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_load_use();
    logic [24:0] st[6];
    logic [41:0] ev[6];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,1,1,0,0,0,1,8,8,0,0,0,0),
           si(0,1,0,0,0,0,1,5,2,5,1,0,0), si(0,1,0,0,0,0,0,0,0,0,0,0,0),
           si(0,0,0,0,0,0,1,8,8,0,0,0,0), si(0,1,0,0,0,0,0,0,0,0,0,0,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_LU,0,0,0,0), ex(EN_LU,0,0,0,1),
           ex(EN_ALL,0,0,0,2), ex(EN_OFF,0,0,0,2), ex(EN_ALL,0,0,0,3)};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL load_use step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_dwait();
    logic [24:0] st[6];
    logic [41:0] ev[6];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,1,0,1,0,0,0,0,0,0,0,0,0),
           si(0,1,0,1,0,0,0,0,0,0,0,0,0), si(0,1,0,1,0,0,0,0,0,0,0,0,0),
           si(0,1,1,1,0,0,0,0,0,0,0,0,0), si(0,1,0,0,0,0,0,0,0,0,0,0,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_OFF,0,0,0,0), ex(EN_OFF,0,0,1,1),
           ex(EN_OFF,0,0,1,2), ex(EN_ALL,0,0,1,3), ex(EN_ALL,0,0,0,3)};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL dwait step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_mask();
    logic [24:0] st[8];
    logic [41:0] ev[8];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,0,1,0,1,0,0,0,0,0,0,0,0),
           si(0,1,0,0,1,0,0,0,0,0,0,0,0), si(0,1,0,0,0,0,0,0,0,0,0,0,0),
           si(0,0,1,0,1,0,0,0,0,0,0,0,0), si(0,0,0,0,1,0,0,0,0,0,0,0,0),
           si(0,1,0,0,1,0,0,0,0,0,0,0,0), si(0,1,0,0,0,0,0,0,0,0,0,0,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_OFF,0,0,0,0), ex(EN_ALL,1,0,0,1),
           ex(EN_ALL,0,0,0,1), ex(EN_OFF,0,0,0,1), ex(EN_OFF,1,0,0,2),
           ex(EN_ALL,1,0,0,3), ex(EN_ALL,0,0,0,3)};
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL mask step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_branch();
    logic [24:0] st[6];
    logic [41:0] ev[6];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,1,0,0,0,0,1,8,8,0,0,1,0),
           si(0,1,0,0,0,0,1,8,8,0,0,0,1), si(0,1,0,0,0,0,0,0,0,0,0,0,1),
           si(0,1,0,0,0,0,0,0,0,0,0,1,1), si(0,0,0,0,0,0,0,0,0,0,0,1,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_BR,0,0,0,0), ex(EN_LU,0,0,0,0),
           ex(EN_JMP,0,0,0,1), ex(EN_BR,0,0,0,1), ex(EN_OFF,0,0,0,1)};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL branch step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_halt();
    logic [24:0] st[8];
    logic [41:0] ev[8];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,0,0,0,0,1,0,0,0,0,0,0,0),
           si(0,1,0,0,0,1,0,0,0,0,0,0,0), si(0,1,0,0,0,0,0,0,0,0,0,0,0),
           si(0,0,1,0,1,0,0,0,0,0,0,0,0), si(0,1,1,0,0,0,0,0,0,0,0,1,0),
           si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,1,0,0,0,0,0,0,0,0,0,0,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_OFF,0,0,0,0), ex(EN_ALL,0,0,0,1),
           ex(EN_OFF,0,1,2,1), ex(EN_OFF,0,1,2,1), ex(EN_OFF,0,1,2,1),
           ex(EN_OFF,0,0,0,0), ex(EN_ALL,0,0,0,0)};
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL halt step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid_dwait();
    logic [24:0] st[5];
    logic [41:0] ev[5];
    logic [41:0] e;
    st = '{si(1,0,0,0,0,0,0,0,0,0,0,0,0), si(0,1,0,1,0,0,0,0,0,0,0,0,0),
           si(0,1,0,1,0,0,0,0,0,0,0,0,0), si(1,1,0,1,0,0,0,0,0,0,0,0,0),
           si(0,1,0,0,0,0,0,0,0,0,0,0,0)};
    ev = '{ex(EN_OFF,0,0,0,0), ex(EN_OFF,0,0,0,0), ex(EN_OFF,0,0,1,1),
           ex(EN_OFF,0,0,0,0), ex(EN_ALL,0,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(st[i]);
      sb.push_back(ev[i]);
      #2;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_dwait step %0d: got %h expected %h", i, obs, e);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  initial begin
    apply_stimulus(si(1,0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge CLK);
    test_reset();
    test_normal();
    test_load_use();
    test_dwait();
    test_mask();
    test_branch();
    test_halt();
    test_reset_mid_dwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
